// File: rtl/ram_responder.sv
// Memory-side responder for the MFA/MFC handshake: byte-addressable big-endian RAM
// with byte/halfword/word access and a fixed number of wait states per request.
module ram_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  MFA,
    input  logic                  RW,
    input  logic [1:0]            dataSize,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [31:0]           dataIn,
    output logic [31:0]           dataOut,
    output logic                  MFC,
    output logic                  addrError
);

    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WAIT, S_DONE} state_e;

    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    rw_q, rw_d;
    logic [1:0]              size_q, size_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             din_q, din_d;
    logic [31:0]             dout_q, dout_d;
    logic                    mfc_q, mfc_d;
    logic                    aerr_q, aerr_d;

    logic [7:0]              mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   a0, a1, a2, a3;
    logic [31:0]             rd_word, rd_data;
    logic                    err, finish, commit;

    assign a0 = addr_q;
    assign a1 = addr_q + ADDR_WIDTH'(1);
    assign a2 = addr_q + ADDR_WIDTH'(2);
    assign a3 = addr_q + ADDR_WIDTH'(3);

    // Big-endian: the lowest address lands in the most significant byte.
    assign rd_word = {mem[a0], mem[a1], mem[a2], mem[a3]};

    always_comb begin
        err     = 1'b0;
        rd_data = 32'd0;
        case (size_q)
            2'b00:   rd_data = {24'd0, rd_word[31:24]};
            2'b01: begin
                rd_data = {16'd0, rd_word[31:16]};
                err     = addr_q[0];
            end
            2'b10: begin
                rd_data = rd_word;
                err     = (addr_q[1:0] != 2'b00);
            end
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        size_d  = size_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        aerr_d  = aerr_q;
        finish  = 1'b0;
        commit  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MFA) begin
                    state_d = S_ACCEPT;
                    cnt_d   = 4'd0;
                    rw_d    = RW;
                    size_d  = dataSize;
                    addr_d  = address;
                    din_d   = dataIn;
                end
            end
            S_ACCEPT: begin
                if (!MFA) begin
                    state_d = S_IDLE;
                end else if (WAIT_N == 4'd0) begin
                    finish = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 4'd1;
                end
            end
            S_WAIT: begin
                if (!MFA) begin
                    state_d = S_IDLE;
                end else if (cnt_q == WAIT_N) begin
                    finish = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                if (!MFA) begin
                    state_d = S_IDLE;
                    mfc_d   = 1'b0;
                    aerr_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Completion: response registers and the memory write share one edge.
        if (finish) begin
            state_d = S_DONE;
            mfc_d   = 1'b1;
            aerr_d  = err;
            if (err)
                dout_d = 32'd0;
            else if (!rw_q)
                dout_d = rd_data;
            commit = rw_q && !err && !reset;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rw_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            din_q   <= 32'd0;
            dout_q  <= 32'd0;
            mfc_q   <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            aerr_q  <= aerr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; contents survive a reset.
    always_ff @(posedge Clk) begin
        if (commit) begin
            case (size_q)
                2'b00: mem[a0] <= din_q[7:0];
                2'b01: begin
                    mem[a0] <= din_q[15:8];
                    mem[a1] <= din_q[7:0];
                end
                default: begin
                    mem[a0] <= din_q[31:24];
                    mem[a1] <= din_q[23:16];
                    mem[a2] <= din_q[15:8];
                    mem[a3] <= din_q[7:0];
                end
            endcase
        end
    end

    assign dataOut   = dout_q;
    assign MFC       = mfc_q;
    assign addrError = aerr_q;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: two instances (0 and 2 wait states) checked
// against a byte-array reference model with randomized and directed requests.
module tb_ram_responder;

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       mfa;
    logic             rw;
    logic [1:0]       data_size;
    logic [8:0]       address;
    logic [31:0]      data_in;
    logic [1:0][31:0] dout;
    logic [1:0]       mfc;
    logic [1:0]       aerr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    exp_t        exp_q[$];
    logic [7:0]  model_mem [2][512];
    logic [31:0] last_dout [2];
    logic [1:0]  prev_mfc = 2'b00;

    always #5 clk = ~clk;

    ram_responder #(.ADDR_WIDTH(9), .DEPTH(512), .WAIT_CYCLES(0)) u_dut0 (
        .Clk(clk), .reset(reset), .MFA(mfa[0]), .RW(rw), .dataSize(data_size),
        .address(address), .dataIn(data_in), .dataOut(dout[0]), .MFC(mfc[0]),
        .addrError(aerr[0])
    );

    ram_responder #(.ADDR_WIDTH(9), .DEPTH(512), .WAIT_CYCLES(2)) u_dut1 (
        .Clk(clk), .reset(reset), .MFA(mfa[1]), .RW(rw), .dataSize(data_size),
        .address(address), .dataIn(data_in), .dataOut(dout[1]), .MFC(mfc[1]),
        .addrError(aerr[1])
    );

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    endtask

    // Reference model: applies the request to a plain byte array and predicts the response.
    function automatic exp_t model(input int d, input logic rw_i, input logic [1:0] sz,
                                   input logic [8:0] a, input logic [31:0] din_i);
        exp_t        e;
        int          n;
        logic [8:0]  ai;
        logic [31:0] v;
        e.dut = d;
        e.err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        n = 1 << sz;
        if (e.err) begin
            last_dout[d] = 32'd0;
        end else if (!rw_i) begin
            v = 32'd0;
            for (int i = 0; i < n; i++) begin
                ai = a + 9'(i);
                v  = (v << 8) | 32'(model_mem[d][ai]);
            end
            last_dout[d] = v;
        end else begin
            for (int i = 0; i < n; i++) begin
                ai = a + 9'(i);
                model_mem[d][ai] = 8'(din_i >> (8 * (n - 1 - i)));
            end
        end
        e.data = last_dout[d];
        return e;
    endfunction

    task automatic scramble();
        address   = 9'($urandom);
        data_in   = $urandom;
        rw        = 1'($urandom);
        data_size = 2'($urandom);
    endtask

    task automatic do_req(input int d, input logic rw_i, input logic [1:0] sz,
                          input logic [8:0] a, input logic [31:0] din_i, input int hold);
        exp_t e;
        int   cnt;
        @(negedge clk);
        rw = rw_i; data_size = sz; address = a; data_in = din_i;
        mfa[d] = 1'b1;
        e = model(d, rw_i, sz, a, din_i);
        exp_q.push_back(e);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) scramble();
        end while (!mfc[d] && cnt < 40);
        check($sformatf("mfc_latency_dut%0d", d), 32'(cnt - 1), 32'(wait_of(d) + 1));
        for (int k = 0; k < hold; k++) begin
            scramble();
            @(negedge clk);
            check("hold_mfc", 32'(mfc[d]), 32'd1);
            check("hold_dout", dout[d], e.data);
            check("hold_aerr", 32'(aerr[d]), 32'(e.err));
        end
        mfa[d] = 1'b0;
        @(negedge clk);
        check("drop_mfc", 32'(mfc[d]), 32'd0);
        check("drop_aerr", 32'(aerr[d]), 32'd0);
        check("drop_dout_held", dout[d], e.data);
    endtask

    // Request on the 2-wait-state instance, killed in its first WAIT cycle.
    task automatic do_abort(input logic use_reset, input logic [1:0] sz,
                            input logic [8:0] a, input logic [31:0] din_i);
        @(negedge clk);
        rw = 1'b1; data_size = sz; address = a; data_in = din_i;
        mfa[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (use_reset) reset = 1'b1;
        else           mfa[1] = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        mfa[1] = 1'b0;
        if (use_reset) begin
            last_dout[0] = 32'd0;
            last_dout[1] = 32'd0;
            for (int d = 0; d < 2; d++) begin
                check("rst_dout", dout[d], 32'd0);
                check("rst_mfc", 32'(mfc[d]), 32'd0);
                check("rst_aerr", 32'(aerr[d]), 32'd0);
            end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort_no_mfc", 32'(mfc[1]), 32'd0);
        end
    endtask

    // Monitor: every rising MFC consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (mfc[d] && !prev_mfc[d]) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_mfc: dut%0d asserted MFC, expected no response", d);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_dut", 32'(d), 32'(e.dut));
                    check("resp_data", dout[d], e.data);
                    check("resp_aerr", 32'(aerr[d]), 32'(e.err));
                end
            end
        end
        prev_mfc = mfc;
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int         r;
        int         d;
        logic [1:0] sz;
        logic [8:0] a;
        reset = 1'b1; mfa = 2'b00; rw = 1'b0; data_size = 2'b00; address = '0; data_in = '0;
        last_dout[0] = 32'd0;
        last_dout[1] = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("reset_dout", dout[i], 32'd0);
            check("reset_mfc", 32'(mfc[i]), 32'd0);
            check("reset_aerr", 32'(aerr[i]), 32'd0);
        end

        // Fill both memories so every later read has a known value.
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 128; w++)
                do_req(i, 1'b1, 2'b10, 9'(w * 4), $urandom, 0);

        // Directed sequence on the 2-wait-state instance.
        do_req(1, 1'b1, 2'b10, 9'h010, 32'hDEADBEEF, 0);
        do_req(1, 1'b0, 2'b10, 9'h010, 32'h0, 0);
        for (int i = 0; i < 4; i++) do_req(1, 1'b0, 2'b00, 9'(16 + i), 32'h0, 0);
        do_req(1, 1'b1, 2'b01, 9'h012, 32'h00001234, 0);
        do_req(1, 1'b0, 2'b10, 9'h010, 32'h0, 0);
        do_req(1, 1'b1, 2'b00, 9'h011, 32'h00000077, 0);
        do_req(1, 1'b0, 2'b10, 9'h010, 32'h0, 0);
        do_req(1, 1'b0, 2'b10, 9'h013, 32'h0, 0);
        do_req(1, 1'b1, 2'b01, 9'h011, 32'h0000FFFF, 0);
        do_req(1, 1'b0, 2'b10, 9'h010, 32'h0, 0);
        do_req(1, 1'b0, 2'b11, 9'h010, 32'h0, 0);
        do_req(1, 1'b0, 2'b10, 9'h020, 32'h0, 0);
        do_abort(1'b0, 2'b10, 9'h020, 32'hAAAAAAAA);
        do_req(1, 1'b0, 2'b10, 9'h020, 32'h0, 0);
        do_abort(1'b1, 2'b10, 9'h020, 32'hAAAAAAAA);
        do_req(1, 1'b0, 2'b10, 9'h020, 32'h0, 0);
        do_req(1, 1'b0, 2'b10, 9'h010, 32'h0, 5);
        @(negedge clk);
        do_req(1, 1'b0, 2'b01, 9'h010, 32'h0, 0);

        // Zero-wait-state instance.
        do_req(0, 1'b0, 2'b10, 9'h010, 32'h0, 3);
        do_req(0, 1'b1, 2'b01, 9'h1FE, 32'h0000BEEF, 0);
        do_req(0, 1'b0, 2'b10, 9'h1FC, 32'h0, 2);

        // Randomized traffic on both instances, with occasional aborts.
        for (int n = 0; n < 200; n++) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 7));
            sz = (r < 3) ? 2'b00 : (r < 5) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
            a = 9'($urandom);
            if ($urandom_range(0, 3) != 0) a = (sz == 2'b01) ? {a[8:1], 1'b0} : {a[8:2], 2'b00};
            if ($urandom_range(0, 11) == 0)
                do_abort(1'($urandom), sz, a, $urandom);
            else
                do_req(d, 1'($urandom), sz, a, $urandom, int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
